// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional same-cycle write-to-read bypass is enabled with REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Clear-sweep controller: walks every register index once, one per cycle,
// and tells the array which entry to zero while clr_busy is high.
module regfile_mp_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A request seen while already sweeping is dropped, not queued.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_we   = clr_busy;
    assign clr_addr = idx;

endmodule

// File: rtl/regfile_mp.sv
// Register file with two write ports, NRD combinational read ports and a
// one-entry-per-cycle clear sweep. Define REGFILE_MP_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DW       = DW_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              clr_req,
    output logic              clr_busy
);

    logic [DW-1:0] mem [NREG];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_en0, wr_en1;

    regfile_mp_clr_fsm #(
        .NREG(NREG)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_en0 = we0 && !clr_busy;
    assign wr_en1 = we1 && !clr_busy;

    // Priority per entry: hardwired zero, then sweep, then port 1, then port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ZERO_REG != 0 && i == 0) begin
                    mem[i] <= '0;
                end else if (clr_we && clr_addr == AW'(i)) begin
                    mem[i] <= '0;
                end else if (wr_en1 && wa1 == AW'(i)) begin
                    mem[i] <= wd1;
                end else if (wr_en0 && wa0 == AW'(i)) begin
                    mem[i] <= wd0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] val;

        assign addr = ra[k*AW +: AW];

        always_comb begin
            val = mem[addr];
`ifdef REGFILE_MP_BYPASS_EN
            // Bypass is held off under reset so rd stays 0 while rst_n is low.
            if (rst_n && !clr_busy) begin
                if (we0 && wa0 == addr) begin
                    val = wd0;
                end
                if (we1 && wa1 == addr) begin
                    val = wd1;
                end
            end
`endif
            if (ZERO_REG != 0 && addr == '0) begin
                val = '0;
            end
        end

        assign rd[k*DW +: DW] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: read expectations go through a scoreboard
// queue and are compared once the combinational read data has settled.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic              clr_req;
    logic              clr_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] exp;
    } sb_t;

    sb_t sb_q[$];

    regfile_mp #(
        .DW       (DW),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int port, input int addr, input logic [DW-1:0] exp,
                             input string tag);
        ra[port*AW +: AW] = AW'(addr);
        sb_q.push_back('{tag: tag, port: port, exp: exp});
    endtask

    task automatic compare_all();
        sb_t           e;
        logic [DW-1:0] got;
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = rd[e.port*DW +: DW];
            checks++;
            assert (got === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input int addr, input logic [DW-1:0] data);
        we0 = 1'b1;
        wa0 = AW'(addr);
        wd0 = data;
        step();
        we0 = 1'b0;
    endtask

    initial begin
        int            cycles;
        logic [DW-1:0] byp_exp;

        rst_n   = 1'b0;
        we0     = 1'b0;
        we1     = 1'b0;
        wa0     = '0;
        wa1     = '0;
        wd0     = '0;
        wd1     = '0;
        ra      = '0;
        clr_req = 1'b0;

        // Reset: reads zero during and after reset, controller idle
        step();
        wd0 = 32'hFFFF_FFFF;
        wa0 = 5'd7;
        we0 = 1'b1;
        expect_rd(0, 7, 32'h0, "rst_rd7_during");
        compare_all();
        chk("rst_busy_during", {31'd0, clr_busy}, 32'd0);
        step();
        we0 = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("rst_busy_after", {31'd0, clr_busy}, 32'd0);
        for (int a = 0; a < NREG; a++) begin
            expect_rd(0, a, 32'h0, $sformatf("rst_rd0_a%0d", a));
            expect_rd(1, a, 32'h0, $sformatf("rst_rd1_a%0d", a));
            compare_all();
        end

        // Basic write, and register 0 hardwired to zero
        wr0(8, 32'hDEAD_BEEF);
        expect_rd(0, 8, 32'hDEAD_BEEF, "wr_addr8");
        compare_all();
        wr0(0, 32'h0000_1234);
        expect_rd(0, 0, 32'h0, "wr_addr0_zero");
        compare_all();

        // Colliding writes: port 1 wins
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22;
        step();
        we0 = 1'b0; we1 = 1'b0;
        expect_rd(0, 9, 32'h22, "collide_addr9");
        compare_all();

        // Same-cycle write and read of address 10
`ifdef REGFILE_MP_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h0;
`endif
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h55;
        expect_rd(1, 10, byp_exp, "same_cycle_addr10");
        compare_all();
        step();
        we0 = 1'b0;
        expect_rd(1, 10, 32'h55, "after_write_addr10");
        compare_all();

        // Same-cycle write to address 0 never shows through
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hABCD;
        expect_rd(0, 0, 32'h0, "same_cycle_addr0");
        compare_all();
        step();
        we1 = 1'b0;

        // Fill 1..31 with their index
        for (int a = 1; a < NREG; a++) begin
            wr0(a, DW'(a));
        end
        expect_rd(0, 31, 32'd31, "fill_addr31");
        expect_rd(1, 17, 32'd17, "fill_addr17");
        compare_all();

        // Clear request together with a write: write lands first
        clr_req = 1'b1;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h99;
        step();
        clr_req = 1'b0;
        we0 = 1'b0;
        cycles = 0;
        while (clr_busy === 1'b1 && cycles < 100) begin
            if (cycles == 3) begin
                expect_rd(0, 2, 32'h0, "sweep_cleared2");
                expect_rd(1, 20, 32'd20, "sweep_kept20");
                compare_all();
                expect_rd(0, 12, 32'h99, "sweep_req_write12");
                compare_all();
            end
            if (cycles == 10) begin
                we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA;
                clr_req = 1'b1;
                expect_rd(0, 5, 32'h0, "sweep_no_bypass5");
                compare_all();
            end
            if (cycles == 11) begin
                we0 = 1'b0;
                clr_req = 1'b0;
            end
            cycles++;
            step();
        end
        chk("sweep_busy_cycles", DW'(cycles), 32'd32);
        for (int a = 0; a < NREG; a++) begin
            expect_rd(a % 2, a, 32'h0, $sformatf("post_sweep_a%0d", a));
            compare_all();
        end

        // Reset in the middle of a sweep
        wr0(20, 32'h77);
        expect_rd(0, 20, 32'h77, "pre_abort_addr20");
        compare_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
        end
        chk("abort_busy_before", {31'd0, clr_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy_async", {31'd0, clr_busy}, 32'd0);
        expect_rd(0, 20, 32'h0, "abort_rd20_in_reset");
        compare_all();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("abort_busy_idle", {31'd0, clr_busy}, 32'd0);
        expect_rd(1, 20, 32'h0, "abort_rd20_after");
        compare_all();
        wr0(3, 32'h33);
        expect_rd(0, 3, 32'h33, "abort_idle_accepts_write");
        compare_all();
        chk("abort_busy_stays_low", {31'd0, clr_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DW  32  data width in bits
  NREG  32  number of registers; power of two, >= 4
  NRD  2  number of read ports, 1..4
  ZERO_REG  1  1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary
REQ-002 AW SHALL be a derived constant equal to log2(NREG).
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on its rising edge
  rst_n  input  1  asynchronous, active-low reset
  we0  input  1  write enable, port 0
  wa0  input  AW  write address, port 0
  wd0  input  DW  write data, port 0
  we1  input  1  write enable, port 1
  wa1  input  AW  write address, port 1
  wd1  input  DW  write data, port 1
  ra  input  NRD*AW  read addresses, flattened; port k at bits [k*AW +: AW]
  rd  output  NRD*DW  read data, flattened; port k at bits [k*DW +: DW]
  clr_req  input  1  one-cycle pulse requesting a full clear sweep
  clr_busy  output  1  high while the clear sweep runs

Function
REQ-004 Reads SHALL be combinational: rd[k] = reg[ra[k]], with zero latency.
REQ-005 With ZERO_REG=1, a read of address 0 SHALL return 0, and writes to address 0 SHALL be discarded.
REQ-006 A write SHALL update the array at the rising clk edge where its enable is high; the written value is visible on rd from the next cycle.
REQ-007 If we0 and we1 are both high and wa0==wa1, port 1 SHALL win and the wd0 value SHALL be discarded.
REQ-008 The clear FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-009 In IDLE, clr_req=1 at a clock edge SHALL move the FSM to CLEAR with sweep index 0 and set clr_busy=1.
REQ-010 In CLEAR, one register (index i) SHALL be zeroed per cycle; i SHALL increment until it reaches NREG-1; after zeroing NREG-1 the FSM SHALL return to IDLE with clr_busy=0, so clr_busy is high for exactly NREG cycles.
REQ-011 While clr_busy=1, we0 and we1 SHALL be ignored and clr_req SHALL be ignored (no restart, no queuing).
REQ-012 While clr_busy=1, reads SHALL return current array contents: cleared entries read 0, uncleared entries keep their old value.
REQ-013 clr_req and a write in the same IDLE cycle: the write SHALL commit, then the sweep SHALL start on the following cycle.

Reset
REQ-014 Asserting rst_n=0 SHALL, asynchronously, zero every register, set the FSM to IDLE, zero the sweep index and drive clr_busy=0.
REQ-015 Asserting reset in the middle of a sweep SHALL abort the sweep immediately; after rst_n deassertion the block SHALL be in IDLE with all registers 0.
REQ-016 During reset, rd SHALL read 0 for every address.

Configuration
REQ-017 When the macro REGFILE_MP_BYPASS_EN is defined, a read whose address matches an active write in the same cycle SHALL return that write data (port 1 takes priority over port 0).
REQ-018 The bypass of REQ-017 SHALL NOT apply to address 0 when ZERO_REG=1, nor while clr_busy=1.
REQ-019 When REGFILE_MP_BYPASS_EN is undefined, reads SHALL return the pre-write value in the cycle of the write.

Structure
REQ-020 The package regfile_mp_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the default values of DW, NREG and NRD.
REQ-021 The sub-module regfile_mp_clr_fsm SHALL contain the state register, the sweep index, and the clr_busy and clear-write outputs; the array and the read/bypass logic SHALL remain in regfile_mp.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  Reset, then read every address -> all rd=0 and clr_busy=0.
  we0: addr 8 = 0xDEADBEEF; next cycle read ra[0]=8 -> 0xDEADBEEF. Write addr 0 = 0x1234 -> reads 0 (ZERO_REG=1).
  we0 and we1 both to addr 9, wd0=0x11, wd1=0x22 -> addr 9 reads 0x22.
  Same-cycle write addr 10 = 0x55 with ra[1]=10 -> rd[1]=0x55 when bypass defined, old value 0 when undefined.
  Fill regs 1..31 with their index; pulse clr_req -> clr_busy high exactly 32 cycles; writes during the sweep are dropped; after the sweep every register reads 0.
  Pulse rst_n low in cycle 5 of a sweep with reg 20 = 0x77 -> clr_busy drops immediately; after reset reg 20 reads 0 and the FSM is in IDLE.
